// File: rtl/trace_event_counters_pkg.sv
// Shared constants and types for the trace event counter bank.
// Counter numbering: 0..31 event bits, 32 cycles, 33 retired instructions.
package trace_event_counters_pkg;

  localparam int TRACE_NUM_EVENTS   = 32;
  localparam int CNT_IDX_CYCLES     = 32;
  localparam int CNT_IDX_RETIRE     = 33;
  localparam int NUM_TRACE_COUNTERS = 34;

  typedef logic [5:0] trace_cnt_idx_t;

  // 65-bit retire trace; the valid flag sits in the MSB.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
  } trace_retire_outputs_t;

  function automatic logic cnt_idx_valid(input trace_cnt_idx_t idx);
    return idx < trace_cnt_idx_t'(NUM_TRACE_COUNTERS);
  endfunction

endpackage

// File: rtl/trace_event_counters_event_counter.sv
// One wrapping counter with a sticky carry-out flag.
// clear_all beats clear_sel, which beats a plain increment.
module event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear_all,
  input  logic         clear_sel,
  output logic [W-1:0] value,
  output logic         overflow
);

  logic [W:0] sum;

  assign sum = {1'b0, value} + {{W{1'b0}}, inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value    <= '0;
      overflow <= 1'b0;
    end else if (clear_all) begin
      value    <= '0;
      overflow <= 1'b0;
    end else if (clear_sel) begin
      // Keep this cycle's event so clear-on-read never drops a count.
      value    <= {{(W-1){1'b0}}, inc};
      overflow <= 1'b0;
    end else begin
      value <= sum[W-1:0];
      if (sum[W]) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/trace_event_counters.sv
// Performance counter bank fed by the core trace outputs, read through a
// single-outstanding request/response port with optional clear-on-read.
module trace_event_counters
  import trace_event_counters_pkg::*;
#(
  parameter int COUNTER_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [31:0]          events,
  input  logic [64:0]          retire,
  input  logic                 clear_all,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_index,
  input  logic                 req_clear,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [COUNTER_W-1:0] resp_data,
  output logic                 resp_overflow,
  output logic                 resp_error
);

  trace_retire_outputs_t          retire_s;
  logic                           unused_retire;
  logic                           accept;
  logic                           idx_ok;
  logic [NUM_TRACE_COUNTERS-1:0]  inc;
  logic [NUM_TRACE_COUNTERS-1:0]  clear_sel;
  logic [NUM_TRACE_COUNTERS-1:0]  cnt_ovf;
  logic [COUNTER_W-1:0]           cnt_value [NUM_TRACE_COUNTERS];
  logic [COUNTER_W-1:0]           sel_value;
  logic                           sel_ovf;

  assign retire_s      = retire;
  assign unused_retire = ^{retire_s.pc, retire_s.instruction};

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign idx_ok    = cnt_idx_valid(req_index);

  always_comb begin
    inc                             = '0;
    inc[TRACE_NUM_EVENTS-1:0]       = events & {TRACE_NUM_EVENTS{enable}};
    inc[CNT_IDX_CYCLES]             = enable;
    inc[CNT_IDX_RETIRE]             = enable && retire_s.valid;
  end

  for (genvar g = 0; g < NUM_TRACE_COUNTERS; g++) begin : g_cnt
    assign clear_sel[g] = accept && req_clear && idx_ok &&
                          (req_index == trace_cnt_idx_t'(g));

    event_counter #(
      .W (COUNTER_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[g]),
      .clear_all (clear_all),
      .clear_sel (clear_sel[g]),
      .value     (cnt_value[g]),
      .overflow  (cnt_ovf[g])
    );
  end

  // Mux sees pre-increment values, so a read returns the count at accept time.
  always_comb begin
    sel_value = '0;
    sel_ovf   = 1'b0;
    if (idx_ok) begin
      sel_value = cnt_value[req_index];
      sel_ovf   = cnt_ovf[req_index];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_overflow <= 1'b0;
      resp_error    <= 1'b0;
    end else if (accept) begin
      resp_valid    <= 1'b1;
      resp_data     <= sel_value;
      resp_overflow <= sel_ovf;
      resp_error    <= !idx_ok;
    end else if (resp_ready) begin
      resp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_event_counters.sv
// Directed self-checking bench for trace_event_counters (8-bit counters).
module tb_trace_event_counters;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] events;
  logic [64:0] retire;
  logic        clear_all;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_index;
  logic        req_clear;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic        resp_overflow;
  logic        resp_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rd_data;
  logic       rd_ovf;
  logic       rd_err;

  always #5 clk = ~clk;

  trace_event_counters #(.COUNTER_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .events        (events),
    .retire        (retire),
    .clear_all     (clear_all),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_index     (req_index),
    .req_clear     (req_clear),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_overflow (resp_overflow),
    .resp_error    (resp_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one read at a negedge, return with the response captured.
  task automatic rd(input logic [5:0] idx, input logic clr);
    int n;
    req_valid  = 1'b1;
    req_index  = idx;
    req_clear  = clr;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_clear = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rd_resp_valid", 64'(resp_valid), 64'(1));
    rd_data = resp_data;
    rd_ovf  = resp_overflow;
    rd_err  = resp_error;
  endtask

  task automatic pulse_clear_all();
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; events = '0; retire = '0; clear_all = 1'b0;
    req_valid = 1'b0; req_index = '0; req_clear = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_resp_ovf", 64'(resp_overflow), 64'(0));
    check("rst_resp_err", 64'(resp_error), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));

    // Reset mid-stream with a pending response
    enable = 1'b1; events = '1; retire = {1'b1, 64'h0};
    repeat (5) @(negedge clk);
    req_valid = 1'b1; req_index = 6'd0; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_pending_valid", 64'(resp_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_drops_valid", 64'(resp_valid), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(1));
    enable = 1'b0; events = '0; retire = '0; resp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(6'd0, 1'b0);
    check("rst_cnt0", 64'(rd_data), 64'(0));
    rd(6'd32, 1'b0);
    check("rst_cnt32", 64'(rd_data), 64'(0));
    rd(6'd33, 1'b0);
    check("rst_cnt33", 64'(rd_data), 64'(0));

    // Event counting: 7 pulses on bit 5, 3 retires, 20 enabled cycles
    pulse_clear_all();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      events = (i % 2 == 0 && i < 14) ? 32'h20 : 32'h0;
      retire = {(i == 1 || i == 5 || i == 9), 64'hdead_beef_0123_4567};
      @(negedge clk);
    end
    events = '0; retire = '0;
    rd(6'd5, 1'b0);
    check("evt_cnt5", 64'(rd_data), 64'(7));
    rd(6'd33, 1'b0);
    check("evt_cnt33", 64'(rd_data), 64'(3));
    rd(6'd32, 1'b0);
    check("evt_cnt32", 64'(rd_data), 64'(22));
    check("evt_cnt32_err", 64'(rd_err), 64'(0));
    enable = 1'b0;

    // Wrap: 257 pulses on bit 0 of an 8-bit counter
    pulse_clear_all();
    enable = 1'b1; events = 32'h1;
    repeat (257) @(negedge clk);
    events = '0;
    rd(6'd0, 1'b0);
    check("wrap_data", 64'(rd_data), 64'(1));
    check("wrap_ovf", 64'(rd_ovf), 64'(1));
    rd(6'd0, 1'b1);
    check("wrap_clr_data", 64'(rd_data), 64'(1));
    check("wrap_clr_ovf", 64'(rd_ovf), 64'(1));
    rd(6'd0, 1'b0);
    check("wrap_after_data", 64'(rd_data), 64'(0));
    check("wrap_after_ovf", 64'(rd_ovf), 64'(0));
    enable = 1'b0;

    // Clear-on-read with an event in the accept cycle
    pulse_clear_all();
    enable = 1'b1; events = 32'h4;
    repeat (10) @(negedge clk);
    rd(6'd2, 1'b1);
    events = '0;
    check("race_resp", 64'(rd_data), 64'(10));
    rd(6'd2, 1'b0);
    check("race_after", 64'(rd_data), 64'(1));
    check("race_after_ovf", 64'(rd_ovf), 64'(0));
    enable = 1'b0;

    // Backpressure: response held while a bad-index request waits
    req_valid = 1'b1; req_index = 6'd2; req_clear = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    check("bp_valid", 64'(resp_valid), 64'(1));
    check("bp_data", 64'(resp_data), 64'(1));
    req_index = 6'd40; req_clear = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_hold_valid", 64'(resp_valid), 64'(1));
      check("bp_hold_data", 64'(resp_data), 64'(1));
      check("bp_hold_err", 64'(resp_error), 64'(0));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_clear = 1'b0;
    check("bad_valid", 64'(resp_valid), 64'(1));
    check("bad_err", 64'(resp_error), 64'(1));
    check("bad_data", 64'(resp_data), 64'(0));
    check("bad_ovf", 64'(resp_overflow), 64'(0));
    @(negedge clk);
    check("bad_consumed", 64'(resp_valid), 64'(0));
    rd(6'd2, 1'b0);
    check("bad_no_change", 64'(rd_data), 64'(1));

    // clear_all in the same cycle as a read of counter 32 at 100
    pulse_clear_all();
    enable = 1'b1;
    repeat (100) @(negedge clk);
    clear_all = 1'b1;
    rd(6'd32, 1'b0);
    clear_all = 1'b0; enable = 1'b0;
    check("ca_resp", 64'(rd_data), 64'(100));
    rd(6'd32, 1'b0);
    check("ca_cnt32", 64'(rd_data), 64'(0));
    rd(6'd2, 1'b0);
    check("ca_cnt2", 64'(rd_data), 64'(0));
    check("ca_cnt2_ovf", 64'(rd_ovf), 64'(0));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
